// File: rtl/sram_mon_pkg.sv
// Shared types for the SRAM access monitors: the per-layer statistics record
// and the access classifier used by both single-port and two-port variants.
package sram_mon_pkg;

    localparam int unsigned MON_ADDR_W = 8;
    localparam int unsigned MON_CNT_W  = 16;
    localparam int unsigned MON_LID_W  = 8;

    typedef struct packed {
        logic [MON_LID_W-1:0]  lid;
        logic [MON_CNT_W-1:0]  rd_cnt;
        logic [MON_CNT_W-1:0]  wr_cnt;
        logic [MON_ADDR_W-1:0] amin;
        logic [MON_ADDR_W-1:0] amax;
        logic                  none;
    } sram_mon_rec_t;

    typedef enum logic [1:0] {
        AccNone  = 2'd0,
        AccRead  = 2'd1,
        AccWrite = 2'd2
    } acc_kind_e;

    // Write wins over read when both enables are set.
    function automatic acc_kind_e classify_access(input logic cs, input logic we,
                                                  input logic oe);
        acc_kind_e kind;
        kind = AccNone;
        if (cs && we) begin
            kind = AccWrite;
        end else if (cs && oe) begin
            kind = AccRead;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sram_mon_rec_fifo.sv
// Two-entry FIFO for monitor records; a push into a full FIFO is accepted
// when a pop frees the head slot on the same edge.
module sram_mon_rec_fifo #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  T     din,
    output logic full,
    input  logic pop,
    output T     dout,
    output logic empty
);

    logic [1:0] r_cnt;
    logic       r_wptr;
    logic       r_rptr;
    T           r_slot0;
    T           r_slot1;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_cnt == 2'd0);
    assign full      = (r_cnt == 2'd2);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_rptr ? r_slot1 : r_slot0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            // When full, wptr == rptr, so a push+pop overwrites the slot being consumed.
            if (w_do_push) begin
                if (r_wptr) begin
                    r_slot1 <= din;
                end else begin
                    r_slot0 <= din;
                end
                r_wptr <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sram_sp_access_mon.sv
// Passive single-port SRAM monitor: per-layer read/write counts and address
// range, published as one record per layer close through a 2-entry FIFO.
module sram_sp_access_mon
    import sram_mon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MON_ADDR_W,
    parameter int unsigned CNT_WIDTH  = MON_CNT_W,
    parameter int unsigned LID_WIDTH  = MON_LID_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  layer_done,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output sram_mon_rec_t         rec,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [LID_WIDTH-1:0] LID_ONE = LID_WIDTH'(1);

    logic                  r_cs;
    logic                  r_we;
    logic                  r_oe;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ld;
    logic                  r_ld_q;

    logic [CNT_WIDTH-1:0]  r_rd_cnt;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_amin;
    logic [ADDR_WIDTH-1:0] r_amax;
    logic                  r_any;
    logic [LID_WIDTH-1:0]  r_lid;

    logic                  r_pend_valid;
    sram_mon_rec_t         r_pend_rec;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic                  r_ovf;

    acc_kind_e             w_kind;
    logic                  w_hit;
    logic                  w_ld_rise;
    logic [CNT_WIDTH-1:0]  w_rd_nxt;
    logic [CNT_WIDTH-1:0]  w_wr_nxt;
    logic [ADDR_WIDTH-1:0] w_amin_nxt;
    logic [ADDR_WIDTH-1:0] w_amax_nxt;
    logic                  w_any_nxt;
    sram_mon_rec_t         w_close_rec;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cs   <= 1'b0;
            r_we   <= 1'b0;
            r_oe   <= 1'b0;
            r_addr <= '0;
            r_ld   <= 1'b0;
            r_ld_q <= 1'b0;
        end else begin
            r_cs   <= cs;
            r_we   <= we;
            r_oe   <= oe;
            r_addr <= addr;
            r_ld   <= layer_done;
            r_ld_q <= r_ld;
        end
    end

    assign w_ld_rise = r_ld & ~r_ld_q;

    always_comb begin
        w_kind     = classify_access(r_cs, r_we, r_oe);
        w_hit      = (w_kind != AccNone);
        w_rd_nxt   = r_rd_cnt;
        w_wr_nxt   = r_wr_cnt;
        if ((w_kind == AccRead) && (r_rd_cnt != '1)) begin
            w_rd_nxt = r_rd_cnt + CNT_ONE;
        end
        if ((w_kind == AccWrite) && (r_wr_cnt != '1)) begin
            w_wr_nxt = r_wr_cnt + CNT_ONE;
        end
        // amin/amax idle at '1 / 0 so the first access always replaces them.
        w_amin_nxt = (w_hit && (r_addr < r_amin)) ? r_addr : r_amin;
        w_amax_nxt = (w_hit && (r_addr > r_amax)) ? r_addr : r_amax;
        w_any_nxt  = r_any | w_hit;
    end

    // Closing record includes the access sampled alongside the layer_done rise.
    always_comb begin
        w_close_rec        = '0;
        w_close_rec.lid    = MON_LID_W'(r_lid);
        w_close_rec.rd_cnt = MON_CNT_W'(w_rd_nxt);
        w_close_rec.wr_cnt = MON_CNT_W'(w_wr_nxt);
        w_close_rec.amin   = MON_ADDR_W'(w_amin_nxt);
        w_close_rec.amax   = MON_ADDR_W'(w_amax_nxt);
        w_close_rec.none   = ~w_any_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_amin   <= '1;
            r_amax   <= '0;
            r_any    <= 1'b0;
            r_lid    <= '0;
        end else if (w_ld_rise) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_amin   <= '1;
            r_amax   <= '0;
            r_any    <= 1'b0;
            r_lid    <= r_lid + LID_ONE;
        end else begin
            r_rd_cnt <= w_rd_nxt;
            r_wr_cnt <= w_wr_nxt;
            r_amin   <= w_amin_nxt;
            r_amax   <= w_amax_nxt;
            r_any    <= w_any_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_valid <= 1'b0;
            r_pend_rec   <= '0;
        end else begin
            r_pend_valid <= w_ld_rise;
            if (w_ld_rise) begin
                r_pend_rec <= w_close_rec;
            end
        end
    end

    assign rec_valid = ~w_empty;
    assign w_pop     = rec_valid & rec_ready;
    assign w_drop    = r_pend_valid & w_full & ~w_pop;

    sram_mon_rec_fifo #(
        .T (sram_mon_rec_t)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_pend_valid),
        .din   (r_pend_rec),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (rec),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_ONE;
            end
            r_ovf <= 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_sram_sp_access_mon.sv
// Bench for sram_sp_access_mon: directed vector table, hand sequences for the
// FIFO/reset corners, and random traffic against a queue-based layer model.
module tb_sram_sp_access_mon;
    import sram_mon_pkg::*;

    logic          clk;
    logic          rstn;
    logic          cs;
    logic          we;
    logic          oe;
    logic [7:0]    addr;
    logic          layer_done;
    logic          rec_ready;
    logic          rec_valid;
    sram_mon_rec_t rec;
    logic [15:0]   drop_cnt;
    logic          ovf;
    logic          rec_valid4;
    sram_mon_rec_t rec4;
    logic [3:0]    drop_cnt4;
    logic          ovf4;

    int n_vec = 0;
    int n_err = 0;

    sram_sp_access_mon u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .addr       (addr),
        .layer_done (layer_done),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec        (rec),
        .drop_cnt   (drop_cnt),
        .ovf        (ovf)
    );

    sram_sp_access_mon #(
        .CNT_WIDTH (4)
    ) u_dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .addr       (addr),
        .layer_done (layer_done),
        .rec_valid  (rec_valid4),
        .rec_ready  (rec_ready),
        .rec        (rec4),
        .drop_cnt   (drop_cnt4),
        .ovf        (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: layers seen at the pins, records delivered 2 edges later.
    int            m_edge;
    int            m_rd, m_wr, m_amin, m_amax, m_lid, m_drop;
    bit            m_any, m_prev_ld, m_ovf;
    sram_mon_rec_t m_flight[$];
    int            m_due[$];
    sram_mon_rec_t m_fifo[$];

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_amin = 255; m_amax = 0; m_any = 0;
        m_lid = 0; m_drop = 0; m_ovf = 0; m_prev_ld = 0;
        m_flight.delete(); m_due.delete(); m_fifo.delete();
    endtask

    task automatic model_edge();
        sram_mon_rec_t r;
        m_edge++;
        if (m_fifo.size() > 0 && rec_ready) void'(m_fifo.pop_front());
        while (m_due.size() > 0 && m_due[0] == m_edge) begin
            void'(m_due.pop_front());
            r = m_flight.pop_front();
            if (m_fifo.size() < 2) m_fifo.push_back(r);
            else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
        end
        if (cs && (we || oe)) begin
            if (we) begin
                if (m_wr < 65535) m_wr++;
            end else begin
                if (m_rd < 65535) m_rd++;
            end
            if (int'(addr) < m_amin) m_amin = int'(addr);
            if (int'(addr) > m_amax) m_amax = int'(addr);
            m_any = 1;
        end
        if (layer_done && !m_prev_ld) begin
            r.lid    = 8'(m_lid);
            r.rd_cnt = 16'(m_rd);
            r.wr_cnt = 16'(m_wr);
            r.amin   = m_any ? 8'(m_amin) : 8'hFF;
            r.amax   = m_any ? 8'(m_amax) : 8'h00;
            r.none   = !m_any;
            m_flight.push_back(r);
            m_due.push_back(m_edge + 2);
            m_rd = 0; m_wr = 0; m_amin = 255; m_amax = 0; m_any = 0;
            m_lid = (m_lid + 1) % 256;
        end
        m_prev_ld = layer_done;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_valid", 64'(rec_valid), 64'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) chk("model_rec", 64'(rec), 64'(m_fifo[0]));
        chk("model_drop", 64'(drop_cnt), 64'(m_drop));
        chk("model_ovf", 64'(ovf), 64'(m_ovf));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cs = 0; we = 0; oe = 0; addr = 8'h00; layer_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic sram_mon_rec_t mk(int lid, int rd, int wr, int amin, int amax, bit none);
        sram_mon_rec_t r;
        r.lid = 8'(lid); r.rd_cnt = 16'(rd); r.wr_cnt = 16'(wr);
        r.amin = 8'(amin); r.amax = 8'(amax); r.none = none;
        return r;
    endfunction

    typedef struct {
        logic          cs, we, oe;
        logic [7:0]    addr;
        logic          ld;
        logic          exp_valid;
        sram_mon_rec_t exp_rec;
    } vec_t;

    // kind: 0 idle, 1 write, 2 read
    function automatic vec_t row(int kind, int a, bit ld, bit ev, sram_mon_rec_t er);
        vec_t v;
        v.cs = (kind != 0); v.we = (kind == 1); v.oe = (kind == 2);
        v.addr = 8'(a); v.ld = ld; v.exp_valid = ev; v.exp_rec = er;
        return v;
    endfunction

    vec_t tab[20];

    initial begin
        sram_mon_rec_t z;
        sram_mon_rec_t hold;
        int pct;
        z = '0;
        tab[0]  = row(1, 5, 0, 0, z);
        tab[1]  = row(1, 9, 0, 0, z);
        tab[2]  = row(1, 2, 0, 0, z);
        tab[3]  = row(2, 7, 0, 0, z);
        tab[4]  = row(2, 1, 0, 0, z);
        tab[5]  = row(0, 0, 1, 0, z);
        tab[6]  = row(0, 0, 0, 0, z);
        tab[7]  = row(0, 0, 0, 1, mk(0, 2, 3, 1, 9, 0));
        tab[8]  = row(0, 0, 0, 0, z);
        tab[9]  = row(0, 0, 1, 0, z);
        tab[10] = row(0, 0, 0, 0, z);
        tab[11] = row(0, 0, 0, 1, mk(1, 0, 0, 255, 0, 1));
        tab[12] = row(0, 0, 0, 0, z);
        tab[13] = row(1, 3, 1, 0, z);
        tab[14] = row(0, 0, 0, 0, z);
        tab[15] = row(0, 0, 0, 1, mk(2, 0, 1, 3, 3, 0));
        tab[16] = row(0, 0, 1, 0, z);
        tab[17] = row(0, 0, 0, 0, z);
        tab[18] = row(0, 0, 0, 1, mk(3, 0, 0, 255, 0, 1));
        tab[19] = row(0, 0, 0, 0, z);

        m_edge = 0;
        rec_ready = 1'b1;
        do_reset();
        chk("rst_valid", 64'(rec_valid), 64'(0));
        chk("rst_rec", 64'(rec), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_valid4", 64'(rec_valid4), 64'(0));

        // Basic record, empty layer, access coincident with layer close.
        for (int i = 0; i < 20; i++) begin
            cs = tab[i].cs; we = tab[i].we; oe = tab[i].oe;
            addr = tab[i].addr; layer_done = tab[i].ld;
            step();
            chk($sformatf("tab%0d_valid", i), 64'(rec_valid), 64'(tab[i].exp_valid));
            if (tab[i].exp_valid) chk($sformatf("tab%0d_rec", i), 64'(rec), 64'(tab[i].exp_rec));
        end

        // Stalled consumer: two queued, third dropped.
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            layer_done = 1; step();
            layer_done = 0; step();
        end
        repeat (3) step();
        chk("stall_valid", 64'(rec_valid), 64'(1));
        chk("stall_head", 64'(rec), 64'(mk(0, 0, 0, 255, 0, 1)));
        chk("stall_drop", 64'(drop_cnt), 64'(1));
        chk("stall_ovf", 64'(ovf), 64'(1));
        hold = rec;
        repeat (2) step();
        chk("stall_stable", 64'(rec), 64'(mk(0, 0, 0, 255, 0, 1)));
        rec_ready = 1'b1;
        step();
        chk("drain_lid1", 64'(rec), 64'(mk(1, 0, 0, 255, 0, 1)));
        chk("drain_changed", 64'(rec == hold), 64'(0));
        step();
        chk("drain_empty", 64'(rec_valid), 64'(0));

        // Full FIFO, push coincides with a pop: no drop.
        do_reset();
        rec_ready = 1'b0;
        layer_done = 1; step();
        layer_done = 0; step();
        layer_done = 1; step();
        layer_done = 0; step();
        step();
        chk("full_head", 64'(rec.lid), 64'(0));
        layer_done = 1; step();
        layer_done = 0; step();
        rec_ready = 1'b1;
        step();
        chk("pp_drop", 64'(drop_cnt), 64'(0));
        chk("pp_ovf", 64'(ovf), 64'(0));
        chk("pp_lid1", 64'(rec.lid), 64'(1));
        step();
        chk("pp_lid2", 64'(rec.lid), 64'(2));
        chk("pp_valid2", 64'(rec_valid), 64'(1));
        step();
        chk("pp_empty", 64'(rec_valid), 64'(0));

        // 4-bit counters saturate at 15.
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cs = 1; we = 1; addr = 8'(16 + i); step();
        end
        cs = 0; we = 0; layer_done = 1; step();
        layer_done = 0; step();
        step();
        chk("sat_valid4", 64'(rec_valid4), 64'(1));
        chk("sat_rec4", 64'(rec4), 64'(mk(0, 0, 15, 16, 35, 0)));
        chk("sat_ovf4", 64'({drop_cnt4, ovf4}), 64'(0));
        chk("sat_wr16", 64'(rec.wr_cnt), 64'(20));

        // Reset mid-layer with a record queued.
        rec_ready = 1'b0;
        layer_done = 1; step();
        layer_done = 0; step();
        step();
        chk("mid_queued", 64'(rec_valid), 64'(1));
        cs = 1; we = 1; addr = 8'h22;
        repeat (3) step();
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rec_valid), 64'(0));
        chk("mid_rst_valid4", 64'(rec_valid4), 64'(0));
        chk("mid_rst_rec", 64'(rec), 64'(0));
        do_reset();
        rec_ready = 1'b1;
        cs = 1; we = 1; addr = 8'h40; step();
        cs = 0; we = 0; layer_done = 1; step();
        layer_done = 0; step();
        step();
        chk("post_rst_valid", 64'(rec_valid), 64'(1));
        chk("post_rst_rec", 64'(rec), 64'(mk(0, 0, 1, 8'h40, 8'h40, 0)));

        // Random traffic against the model, varying consumer throughput.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            pct = (blk % 2 == 0) ? 20 : 85;
            for (int i = 0; i < 400; i++) begin
                cs = ($urandom_range(0, 3) != 0);
                we = $urandom_range(0, 1) == 1;
                oe = $urandom_range(0, 1) == 1;
                addr = 8'($urandom);
                if ($urandom_range(0, 5) == 0) layer_done = ~layer_done;
                rec_ready = ($urandom_range(0, 99) < pct);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
